// File: rtl/obi_arb_pkg.sv
// Shared widths and helpers for the OBI bank arbiter.
package obi_arb_pkg;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_ADDR_W = 32;
    localparam int OBI_BE_W   = 4;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-flight requester-ID FIFO: push on bank grant, pop on bank rvalid.
// No bypass: a full FIFO stays full for the whole cycle even if it pops.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer/count bookkeeping; simultaneous push+pop leaves the count alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= data_i;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_pop) r_rd <= ptr_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/obi_bank_arbiter.sv
// Round-robin arbiter sharing one OBI bank port between NUM_PORTS requesters.
// Request and response paths are purely combinational.
// Optional contention counter: define OBI_ARB_CONFLICT_CNT_EN.
module obi_bank_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_PORTS-1:0]                  req_i,
    input  logic [NUM_PORTS-1:0]                  we_i,
    input  logic [NUM_PORTS-1:0][OBI_BE_W-1:0]    be_i,
    input  logic [NUM_PORTS-1:0][OBI_ADDR_W-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0][OBI_DATA_W-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]                  gnt_o,
    output logic [NUM_PORTS-1:0]                  rvalid_o,
    output logic [NUM_PORTS-1:0][OBI_DATA_W-1:0]  rdata_o,
    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [OBI_BE_W-1:0]                   mem_be_o,
    output logic [OBI_ADDR_W-1:0]                 mem_addr_o,
    output logic [OBI_DATA_W-1:0]                 mem_wdata_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [OBI_DATA_W-1:0]                 mem_rdata_i,
    output logic                                  err_o
`ifdef OBI_ARB_CONFLICT_CNT_EN
    ,
    output logic [31:0]                           conflict_cnt_o
`endif
);
    localparam int IW = clog2_min1(NUM_PORTS);

    logic [IW-1:0] r_ptr;
    logic          r_err;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_idx;
    logic          w_found;
    logic          w_grant;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [IW-1:0] w_head;

    // First requesting port at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = IW'((int'(r_ptr) + i) % NUM_PORTS);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign mem_req_o   = (|req_i) & ~w_full;
    assign w_grant     = mem_req_o & mem_gnt_i;
    assign w_pop       = mem_rvalid_i & ~w_empty;
    assign mem_we_o    = w_found & we_i[w_win];
    assign mem_be_o    = w_found ? be_i[w_win]    : '0;
    assign mem_addr_o  = w_found ? addr_i[w_win]  : '0;
    assign mem_wdata_o = w_found ? wdata_i[w_win] : '0;
    assign err_o       = r_err;

    // One-hot grant back to the winner and rvalid to the FIFO head.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (w_grant) gnt_o[w_win]   = 1'b1;
        if (w_pop)   rvalid_o[w_head] = 1'b1;
    end

    // Read data is broadcast; consumers qualify it with their rvalid.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
        assign rdata_o[p] = mem_rdata_i;
    end

    // Pointer moves past the winner on grant; error is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_grant)
                r_ptr <= (w_win == IW'(NUM_PORTS - 1)) ? '0 : w_win + IW'(1);
            if (mem_rvalid_i && w_empty)
                r_err <= 1'b1;
        end
    end

    obi_arb_id_fifo #(
        .W     (IW),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_grant),
        .pop_i   (w_pop),
        .data_i  (w_win),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef OBI_ARB_CONFLICT_CNT_EN
    logic [31:0] r_conflict;
    assign conflict_cnt_o = r_conflict;

    // Saturating count of issuing cycles with two or more requesters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            r_conflict <= '0;
        else if (mem_req_o && (|(req_i & (req_i - NUM_PORTS'(1)))) && (r_conflict != '1))
            r_conflict <= r_conflict + 32'd1;
    end
`endif
endmodule
